// File: rtl/fft_8p_stream_ctrl.sv
// Streaming sequencer for the 8-point FFT core: serial load, hold for core latency,
// capture into an output bank, serial drain y0..y7. Load and drain overlap (double-buffered).
module fft_8p_stream_ctrl #(
  parameter int WIDTH       = 32,
  parameter int Q_LENGTH    = 16,
  parameter int FFT_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_real,
  input  logic [WIDTH-1:0]     in_img,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_real,
  output logic [WIDTH-1:0]     out_img,
  output logic                 out_last,
  output logic [8*WIDTH-1:0]   fft_x_real,
  output logic [8*WIDTH-1:0]   fft_x_img,
  input  logic [8*WIDTH-1:0]   fft_y_real,
  input  logic [8*WIDTH-1:0]   fft_y_img,
  output logic [15:0]          frame_cnt
);

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} in_state_t;
  typedef enum logic {EMPTY = 1'b0, DRAIN = 1'b1} out_state_t;

  localparam logic [2:0] LAT_C = 3'(FFT_LATENCY);

  if (Q_LENGTH >= WIDTH || FFT_LATENCY < 1 || FFT_LATENCY > 7) begin : g_param_check
    $error("fft_8p_stream_ctrl: unsupported parameter set");
  end

  in_state_t        in_state_r;
  out_state_t       out_state_r;
  logic [2:0]       in_idx_r;
  logic [2:0]       out_idx_r;
  logic [2:0]       lat_cnt_r;
  logic [WIDTH-1:0] xr_r [8];
  logic [WIDTH-1:0] xi_r [8];
  logic [WIDTH-1:0] yr_r [8];
  logic [WIDTH-1:0] yi_r [8];
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [WIDTH-1:0] out_real_r;
  logic [WIDTH-1:0] out_img_r;
  logic [15:0]      frame_cnt_r;

  logic             capture_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic [2:0]       out_idx_nxt_s;

  // Handshake decode, capture condition and parallel core-input packing.
  always_comb begin
    capture_s     = (in_state_r == HOLD) && (lat_cnt_r == LAT_C) && (out_state_r == EMPTY);
    in_fire_s     = in_valid && in_ready_r;
    out_fire_s    = out_valid_r && out_ready;
    out_idx_nxt_s = out_idx_r + 3'd1;
    fft_x_real    = '0;
    fft_x_img     = '0;
    for (int k = 0; k < 8; k++) begin
      fft_x_real[k*WIDTH +: WIDTH] = xr_r[k];
      fft_x_img[k*WIDTH +: WIDTH]  = xi_r[k];
    end
  end

  // Input FSM: collect eight samples, then freeze the bank until the core result is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_r <= LOAD;
      in_idx_r   <= 3'd0;
      lat_cnt_r  <= 3'd0;
      in_ready_r <= 1'b1;
      for (int k = 0; k < 8; k++) begin
        xr_r[k] <= '0;
        xi_r[k] <= '0;
      end
    end else begin
      case (in_state_r)
        LOAD: begin
          if (in_fire_s) begin
            xr_r[in_idx_r] <= in_real;
            xi_r[in_idx_r] <= in_img;
            if (in_idx_r == 3'd7) begin
              in_state_r <= HOLD;
              in_idx_r   <= 3'd0;
              lat_cnt_r  <= 3'd0;
              in_ready_r <= 1'b0;
            end else begin
              in_idx_r <= in_idx_r + 3'd1;
            end
          end
        end
        HOLD: begin
          if (capture_s) begin
            in_state_r <= LOAD;
            in_ready_r <= 1'b1;
          end else if (lat_cnt_r != LAT_C) begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        default: begin
          in_state_r <= LOAD;
          in_idx_r   <= 3'd0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Output FSM: capture the core result into the output bank and drain it in natural order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_r <= EMPTY;
      out_idx_r   <= 3'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_real_r  <= '0;
      out_img_r   <= '0;
      frame_cnt_r <= 16'd0;
      for (int k = 0; k < 8; k++) begin
        yr_r[k] <= '0;
        yi_r[k] <= '0;
      end
    end else begin
      case (out_state_r)
        EMPTY: begin
          if (capture_s) begin
            for (int k = 0; k < 8; k++) begin
              yr_r[k] <= fft_y_real[k*WIDTH +: WIDTH];
              yi_r[k] <= fft_y_img[k*WIDTH +: WIDTH];
            end
            out_state_r <= DRAIN;
            out_idx_r   <= 3'd0;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            out_real_r  <= fft_y_real[WIDTH-1:0];
            out_img_r   <= fft_y_img[WIDTH-1:0];
          end
        end
        DRAIN: begin
          if (out_fire_s) begin
            if (out_idx_r == 3'd7) begin
              out_state_r <= EMPTY;
              out_idx_r   <= 3'd0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
              out_idx_r  <= out_idx_nxt_s;
              out_real_r <= yr_r[out_idx_nxt_s];
              out_img_r  <= yi_r[out_idx_nxt_s];
              out_last_r <= (out_idx_nxt_s == 3'd7);
            end
          end
        end
        default: begin
          out_state_r <= EMPTY;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_real  = out_real_r;
  assign out_img   = out_img_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fft_8p_stream_ctrl.sv
// Bench for fft_8p_stream_ctrl: a 1-cycle DFT core model closes the loop; directed frames
// with hand-computed bins check data, ordering, latency, backpressure, reset and frame-count wrap.
module tb_fft_8p_stream_ctrl;

  localparam int W = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_real;
  logic [W-1:0]   in_img;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_real;
  logic [W-1:0]   out_img;
  logic           out_last;
  logic [8*W-1:0] fft_x_real;
  logic [8*W-1:0] fft_x_img;
  logic [8*W-1:0] fft_y_real;
  logic [8*W-1:0] fft_y_img;
  logic [15:0]    frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs_cyc = 0;

  int twr [8] = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
  int twi [8] = '{0, -46341, -65536, -46341, 0, 46341, 65536, 46341};
  // Hand-computed bins of a unit impulse at x1: exp(-j*pi*k/4) in Q16.
  int e2r [8] = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
  int e2i [8] = '{0, -46341, -65536, -46341, 0, 46341, 65536, 46341};

  fft_8p_stream_ctrl #(.WIDTH(W), .Q_LENGTH(16), .FFT_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_img(in_img),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_img(out_img),
    .out_last(out_last),
    .fft_x_real(fft_x_real), .fft_x_img(fft_x_img),
    .fft_y_real(fft_y_real), .fft_y_img(fft_y_img),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dft_bin(input int k, input bit want_im);
    longint ar, ai, xr, xi;
    int m;
    ar = 0;
    ai = 0;
    for (int n = 0; n < 8; n++) begin
      m  = (k * n) % 8;
      xr = longint'($signed(fft_x_real[n*W +: W]));
      xi = longint'($signed(fft_x_img[n*W +: W]));
      ar = ar + xr * longint'(twr[m]) - xi * longint'(twi[m]);
      ai = ai + xr * longint'(twi[m]) + xi * longint'(twr[m]);
    end
    return want_im ? 32'(ai >>> 16) : 32'(ar >>> 16);
  endfunction

  // Core model with one cycle of latency.
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      fft_y_real[k*W +: W] <= dft_bin(k, 1'b0);
      fft_y_img[k*W +: W]  <= dft_bin(k, 1'b1);
    end
  end

  function automatic logic [31:0] pat_re(input int pat, input int k);
    case (pat)
      0:       return (k == 0) ? ONE : 32'd0;
      1:       return ONE;
      2:       return (k == 1) ? ONE : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pat_im(input int pat, input int k);
    return (pat == 3 && k == 0) ? ONE : 32'd0;
  endfunction

  function automatic logic [31:0] exp_re(input int pat, input int k);
    case (pat)
      0:       return ONE;
      1:       return (k == 0) ? 32'h0008_0000 : 32'd0;
      2:       return 32'(e2r[k]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_im(input int pat, input int k);
    case (pat)
      2:       return 32'(e2i[k]);
      3:       return ONE;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int pat);
    for (int k = 0; k < n; k++) begin
      int guard;
      bit hs;
      guard    = 0;
      hs       = 1'b0;
      in_valid = 1'b1;
      in_real  = pat_re(pat, k);
      in_img   = pat_im(pat, k);
      while (!hs && guard < 100) begin
        hs = in_ready;
        if (hs) last_hs_cyc = cyc;
        tick();
        guard++;
      end
      if (!hs) chk("in_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_real  = '0;
    in_img   = '0;
  endtask

  task automatic collect(input int pat, input string tag, output int first_c, output int last_c);
    int guard;
    first_c   = -1;
    last_c    = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      guard = 0;
      while (!out_valid && guard < 100) begin
        tick();
        guard++;
      end
      if (!out_valid) begin
        chk($sformatf("%s_timeout%0d", tag, k), 32'd0, 32'd1);
      end else begin
        if (k == 0) first_c = cyc;
        if (k == 7) last_c = cyc;
        chk($sformatf("%s_re%0d", tag, k), out_real, exp_re(pat, k));
        chk($sformatf("%s_im%0d", tag, k), out_img, exp_im(pat, k));
        chk($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == 7));
        tick();
      end
    end
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    int hs8 [3];
    int fv [3];
    int lv [3];
    int fa, la, fb, lb, guard;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_real   = '0;
    in_img    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_real", out_real, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_fft_x0", fft_x_real[31:0], 32'd0);

    // Three back-to-back frames: impulse x0, impulse x1, imaginary impulse x0.
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          send(8, (f == 0) ? 0 : f + 1);
          hs8[f] = last_hs_cyc;
        end
      end
      begin
        for (int f = 0; f < 3; f++) begin
          collect((f == 0) ? 0 : f + 1, $sformatf("lat_f%0d", f), fv[f], lv[f]);
        end
      end
    join
    for (int f = 0; f < 3; f++) chk($sformatf("lat_first%0d", f), 32'(fv[f] - hs8[f]), 32'd3);
    chk("lat_period01", 32'(hs8[1] - hs8[0]), 32'd10);
    chk("lat_period12", 32'(fv[2] - fv[1]), 32'd10);
    chk("lat_frame_cnt", 32'(frame_cnt), 32'd3);

    // Backpressure: DC frame held at the output while the next frame loads and stalls.
    out_ready = 1'b0;
    send(8, 1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("bp_first", 32'(cyc - last_hs_cyc), 32'd3);
    send(8, 0);
    repeat (4) tick();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    chk("bp_held_re", out_real, 32'h0008_0000);
    chk("bp_held_last", 32'(out_last), 32'd0);
    chk("bp_held_cnt", 32'(frame_cnt), 32'd3);
    collect(1, "bpA", fa, la);
    chk("bp_gap_valid", 32'(out_valid), 32'd0);
    collect(0, "bpB", fb, lb);
    chk("bp_capture", 32'(fb - la), 32'd2);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd5);

    // Reset with a partially loaded frame.
    out_ready = 1'b1;
    send(4, 1);
    chk("rst1_bank_loaded", fft_x_real[31:0], ONE);
    pulse_reset();
    chk("rst1_in_ready", 32'(in_ready), 32'd1);
    chk("rst1_out_valid", 32'(out_valid), 32'd0);
    chk("rst1_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst1_bank_clear", fft_x_real[31:0], 32'd0);

    // Reset in the middle of a drain.
    send(8, 2);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk("rst2_pre_re", out_real, 32'(e2r[3]));
    pulse_reset();
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_re", out_real, 32'd0);
    chk("rst2_out_im", out_img, 32'd0);
    chk("rst2_out_last", 32'(out_last), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    chk("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
    send(8, 0);
    collect(0, "post_rst", fa, la);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // Frame counter wrap.
    force dut.frame_cnt_r = 16'hFFFF;
    tick();
    release dut.frame_cnt_r;
    tick();
    chk("wrap_pre", 32'(frame_cnt), 32'h0000_FFFF);
    send(8, 1);
    collect(1, "wrap", fa, la);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
